// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM stage. A word-addressed 32-bit RAM sits
// behind a fixed-latency handshake that stalls the pipeline for LATENCY cycles.
module dmem_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        mem_stall,
    output logic        err,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;

    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic        complete;
    logic        capture;
    logic        misaligned;
    logic        mem_we;
    logic [ADDR_W-1:0] idx;

    logic [31:0] mem [2**ADDR_W];

    // The address wraps modulo the array depth; the upper bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cur_addr[31:ADDR_W+2];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value undriven and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_stall = 1'b0;
        complete  = 1'b0;
        capture   = 1'b0;
        cur_we    = req_we;
        cur_addr  = req_addr;
        cur_wdata = req_wdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LAT == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                        capture   = 1'b1;
                        cnt_nxt   = 4'd1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // Once accepted, the access runs from its latched copy so the
                // frozen upstream stages may present anything meanwhile.
                cur_we    = lat_we;
                cur_addr  = lat_addr;
                cur_wdata = lat_wdata;
                if (cnt < LAT) begin
                    mem_stall = 1'b1;
                    cnt_nxt   = cnt + 4'd1;
                end else begin
                    complete  = 1'b1;
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Side effects of a completion are masked while reset is held so a
    // zero-latency request cannot write or flag during reset.
    assign misaligned = (cur_addr[1:0] != 2'b00);
    assign err        = complete & rst & misaligned;
    assign mem_we     = complete & rst & cur_we & ~misaligned;
    assign idx        = cur_addr[ADDR_W+1:2];
    assign rdata      = mem[idx];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (mem_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    // NOTE: the array is deliberately left out of reset; contents survive a
    // reset and the block maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= cur_wdata;
        end
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, log2 of word depth (1024 x 32-bit words).
REQ-002 SHALL provide parameter LATENCY, default 2, stall cycles per access (0..15).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port req_valid  input  1  MEM-stage access request (load or store) this cycle.
REQ-006 SHALL provide port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL provide port req_addr  input  32  byte address (ALU result).
REQ-008 SHALL provide port req_wdata  input  32  store data (forwarded rt value).
REQ-009 SHALL provide port rdata  output  32  load data, valid when req_valid=1 and mem_stall=0.
REQ-010 SHALL provide port mem_stall  output  1  freezes EX/MEM, MEM/WB and upstream while 1.
REQ-011 SHALL provide port err  output  1  one-cycle flag: misaligned access completed.
REQ-012 SHALL provide port stall_cnt  output  32  total stall cycles since reset, saturating.

Function
REQ-013 SHALL implement a 2-state FSM: IDLE, WAIT; 4-bit wait counter cnt.
REQ-014 IDLE, req_valid=0: mem_stall=0, no memory access, stay IDLE.
REQ-015 IDLE, req_valid=1, LATENCY=0: mem_stall=0, access completes this cycle (zero-wait).
REQ-016 IDLE, req_valid=1, LATENCY>0: mem_stall=1 combinationally same cycle; latch req_we/req_addr/req_wdata; cnt<=1; go WAIT.
REQ-017 WAIT, cnt<LATENCY: mem_stall=1, cnt<=cnt+1; request inputs ignored (latched copy used).
REQ-018 WAIT, cnt==LATENCY: mem_stall=0, access completes this cycle; next state IDLE, cnt<=0.
REQ-019 Total stall cycles per access SHALL equal exactly LATENCY; completion cycle never stalled.
REQ-020 Completion cycle of a load: rdata = mem[addr[ADDR_W+1:2]] combinationally.
REQ-021 Completion cycle of a store: mem[addr[ADDR_W+1:2]] <= wdata at the closing edge; rdata = old word.
REQ-022 Address bits [31:ADDR_W+2] SHALL be ignored (address wraps modulo depth).
REQ-023 Misaligned (addr[1:0]!=0): store suppressed; load returns the aligned word; err=1 in completion cycle only.
REQ-024 Request present in IDLE the cycle after a completion SHALL be treated as a new access (back-to-back supported, no bubble).
REQ-025 req_valid dropping during WAIT SHALL NOT abort the access.
REQ-026 rdata outside completion cycles: holds array read of current index, no validity guarantee.
REQ-027 stall_cnt SHALL increment by 1 on every edge where mem_stall=1; saturates at 32'hFFFFFFFF.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, cnt=0, latched request=0, err=0, stall_cnt=0, mem_stall=0 (if req_valid=0).
REQ-029 Reset during WAIT SHALL abort the access; a pending store SHALL NOT be written.
REQ-030 Memory array contents SHALL NOT be affected by reset; unwritten words undefined.

Verification
REQ-031 LATENCY=2: store 0xDEADBEEF to 0x10 -> mem_stall=1 for 2 cycles, then 0; later load 0x10 -> rdata=0xDEADBEEF in completion cycle after 2 stall cycles; stall_cnt=4.
REQ-032 LATENCY=0: store 0x12345678 to 0x4 then load 0x4 back-to-back -> mem_stall never 1, rdata=0x12345678 in second cycle.
REQ-033 LATENCY=2: store 0xAAAA5555 to 0x20, change req_addr/req_wdata to 0x24/0x0 during WAIT -> word 0x20 = 0xAAAA5555, word 0x24 unchanged.
REQ-034 Store 0x11111111 to 0x8, then store 0x22222222 to 0x9 -> err=1 one cycle at completion; load 0x8 -> 0x11111111.
REQ-035 LATENCY=3: store 0x55 to 0x30, assert rst=0 in second stall cycle -> mem_stall, stall_cnt drop to 0 immediately; load 0x30 returns prior contents, not 0x55.
REQ-036 ADDR_W=10: store 0x77 to 0x1000 -> load 0x0 returns 0x77 (wrap).
